mat4_chain_mul: RTL and testbench

Sequential fixed-point 4x4 matrix chain multiplier for the transform stage. It accepts a start command and a count N, then takes N matrices over a valid/ready stream, and returns P = M1 × M2 × … × MN. A typical use is MVP = projection × view × model, with projection sent first. It replaces single-shot combinational matrix products with a shared 4-multiplier datapath that is parametrised in element width, fraction bits and maximum chain length, and it adds rounding, saturation and handshaking.

---
 rtl/mat4_chain_mul_if.sv | 26 ++
 rtl/mat4_chain_mul.sv | 167 ++++++++++++++++
 tb/tb_mat4_chain_mul.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mat4_chain_mul_if.sv
// Command, matrix stream and result bundle for mat4_chain_mul.
// The master drives the job and the matrices; the slave (the multiplier) returns status and the product.
interface mat4_chain_mul_if #(
  parameter int W  = 16,
  parameter int CW = 3
);
  logic                 start;
  logic [CW-1:0]        num_mat;
  logic                 mat_valid;
  logic                 mat_ready;
  logic [15:0][W-1:0]   mat_in;
  logic                 busy;
  logic                 done;
  logic                 sat;
  logic [15:0][W-1:0]   result;

  modport master (
    output start, num_mat, mat_valid, mat_in,
    input  mat_ready, busy, done, sat, result
  );

  modport slave (
    input  start, num_mat, mat_valid, mat_in,
    output mat_ready, busy, done, sat, result
  );
endinterface

// File: rtl/mat4_chain_mul.sv
// Sequential fixed-point 4x4 matrix chain product P = M1 x M2 x ... x MN.
// One output element per MUL cycle from four shared signed multipliers, with round-half-up and saturation.
module mat4_chain_mul #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int NMAX = 4,
  parameter int CW   = $clog2(NMAX + 1)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  mat4_chain_mul_if.slave bus
);
  localparam int SW = 2 * W + 2;

  typedef logic [15:0][W-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, LOAD, MUL, FIN} state_t;

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (FRAC - 1);
  localparam logic signed [W-1:0]  WMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  WMIN = {1'b1, {(W-1){1'b0}}};

  function automatic mat_t identity();
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = W'(1) << FRAC;
    return m;
  endfunction

  // Returns {clamped, value}; the shift is arithmetic, so rounding is toward +inf on ties.
  function automatic logic [W:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + RND) >>> FRAC;
    if (r > SW'(WMAX)) return {1'b1, WMAX};
    if (r < SW'(WMIN)) return {1'b1, WMIN};
    return {1'b0, r[W-1:0]};
  endfunction

  state_t        state_q, state_d;
  mat_t          acc_q, acc_d;
  mat_t          b_q, b_d;
  mat_t          t_q, t_d;
  mat_t          result_q, result_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] num_clamped;
  logic [3:0]    e_q, e_d;
  logic          first_q, first_d;
  logic          sat_q, sat_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          mat_ready_q, mat_ready_d;

  logic signed [W-1:0]   a_el, b_el;
  logic signed [2*W-1:0] prod;
  logic signed [SW-1:0]  dot;
  logic [W:0]            rs;

  // Row e>>2 of A against column e&3 of B
  always_comb begin
    a_el = '0;
    b_el = '0;
    prod = '0;
    dot  = '0;
    for (int k = 0; k < 4; k++) begin
      a_el = acc_q[{e_q[3:2], 2'(k)}];
      b_el = b_q[{2'(k), e_q[1:0]}];
      prod = (2*W)'(a_el) * (2*W)'(b_el);
      dot  = dot + SW'(prod);
    end
    rs = round_sat(dot);
  end

  assign num_clamped = (bus.num_mat > CW'(NMAX)) ? CW'(NMAX) : bus.num_mat;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    t_d     = t_q;
    rem_d   = rem_q;
    e_d     = e_q;
    first_d = first_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sat_d = 1'b0;
          if (bus.num_mat == '0) begin
            acc_d   = identity();
            state_d = FIN;
          end else begin
            rem_d   = num_clamped;
            first_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.mat_valid) begin
          rem_d = rem_q - CW'(1);
          if (first_q) begin
            acc_d   = bus.mat_in;
            first_d = 1'b0;
            if (rem_q == CW'(1)) state_d = FIN;
          end else begin
            b_d     = bus.mat_in;
            e_d     = '0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        t_d[e_q] = rs[W-1:0];
        if (rs[W]) sat_d = 1'b1;
        e_d = e_q + 4'd1;
        // T is buffered separately because row r of A is still needed for the rest of the row
        if (e_q == 4'd15) begin
          acc_d   = t_d;
          state_d = (rem_q != '0) ? LOAD : FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mat_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    result_d    = (state_d == FIN) ? acc_d : result_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      e_q         <= '0;
      first_q     <= 1'b0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mat_ready_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      e_q         <= e_d;
      first_q     <= first_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mat_ready_q <= mat_ready_d;
      result_q    <= result_d;
    end
  end

  // Matrix storage needs no reset: the control path decides when it is meaningful
  always_ff @(posedge Clk) begin
    acc_q <= acc_d;
    b_q   <= b_d;
    t_q   <= t_d;
  end

  assign bus.mat_ready = mat_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_mat4_chain_mul.sv
// Bench for mat4_chain_mul: fixed vector table, reset and MVP sequences, and random jobs
// checked against a plain-arithmetic chain product model.
module tb_mat4_chain_mul;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int NMAX = 4;
  localparam int CW   = 3;
  localparam longint LMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint LMIN = -(longint'(1) <<< (W - 1));

  typedef logic [15:0][W-1:0] mat_t;
  typedef struct {
    int               n;
    logic [3:0][255:0] m;
    logic [255:0]     er;
    bit               es;
    int               el;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  mat_t jobm [NMAX];

  mat4_chain_mul_if #(.W(W), .CW(CW)) bus ();

  mat4_chain_mul #(.W(W), .FRAC(FRAC), .NMAX(NMAX), .CW(CW)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mat_t dg(input logic [W-1:0] x);
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = x;
    return m;
  endfunction

  function automatic mat_t one(input int idx, input logic [W-1:0] x);
    mat_t m;
    m = '0;
    m[idx] = x;
    return m;
  endfunction

  function automatic vec_t mkv(input int n, input mat_t a, input mat_t b, input mat_t c,
                               input mat_t d, input mat_t er, input bit es, input int el);
    vec_t v;
    v.n = n; v.m[0] = a; v.m[1] = b; v.m[2] = c; v.m[3] = d;
    v.er = er; v.es = es; v.el = el;
    return v;
  endfunction

  function automatic int eff(input int n);
    return (n > NMAX) ? NMAX : n;
  endfunction

  function automatic int exp_lat(input int n);
    return (eff(n) == 0) ? 1 : 2 + 17 * (eff(n) - 1);
  endfunction

  // Golden chain product: exact integer dot products, floor((x + half) / 2^FRAC), clamp
  function automatic void model(input int n, output mat_t p, output bit s);
    mat_t   a, t;
    longint acc, r;
    int     ne;
    ne = eff(n);
    s  = 1'b0;
    t  = '0;
    a  = (ne == 0) ? dg(16'h0100) : jobm[0];
    for (int m = 1; m < ne; m++) begin
      for (int i = 0; i < 16; i++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += longint'($signed(a[(i/4)*4+k])) * longint'($signed(jobm[m][k*4+(i%4)]));
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > LMAX) begin r = LMAX; s = 1'b1; end
        else if (r < LMIN) begin r = LMIN; s = 1'b1; end
        t[i] = r[W-1:0];
      end
      a = t;
    end
    p = a;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Runs one job; lat is cycles from the start edge to the done cycle (-1 on timeout)
  task automatic run_job(input int n, input bit hs, output int lat, output int taken);
    int ne;
    ne    = eff(n);
    lat   = -1;
    taken = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_mat = CW'(n);
    bus.mat_valid = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      bus.start     = hs && ($urandom_range(0, 3) == 0);
      bus.num_mat   = CW'($urandom_range(0, 7));
      bus.mat_valid = hs ? 1'($urandom_range(0, 1)) : (taken < ne);
      if (taken < ne) bus.mat_in = jobm[taken];
      else for (int i = 0; i < 16; i++) bus.mat_in[i] = W'($urandom);
      if (bus.mat_valid && bus.mat_ready) taken++;
    end
    bus.start     = 1'b0;
    bus.mat_valid = 1'b0;
    if (lat < 0) chk("done_timeout", 256'(0), 256'(1));
  endtask

  initial begin
    vec_t v [10];
    mat_t pexp;
    bit   sexp;
    int   lat;
    int   tk;
    int   n;
    bit   hs;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_mat = '0;
    bus.mat_valid = 1'b0;
    bus.mat_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_result", bus.result, 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_ready", 256'(bus.mat_ready), 256'(0));
    chk("rst_sat", 256'(bus.sat), 256'(0));
    rst_n = 1'b1;

    v[0] = mkv(0, '0, '0, '0, '0, dg(16'h0100), 0, 1);
    v[1] = mkv(2, dg(16'h0100), dg(16'h0100), '0, '0, dg(16'h0100), 0, 19);
    v[2] = mkv(2, one(0, 16'h0001), one(0, 16'h0080), '0, '0, one(0, 16'h0001), 0, 19);
    v[3] = mkv(2, one(0, 16'hFFFF), one(0, 16'h0080), '0, '0, '0, 0, 19);
    v[4] = mkv(2, dg(16'h0180), dg(16'h0180), '0, '0, dg(16'h0240), 0, 19);
    v[5] = mkv(2, dg(16'h7FFF), dg(16'h7FFF), '0, '0, dg(16'h7FFF), 1, 19);
    v[6] = mkv(1, dg(16'h8001), '0, '0, '0, dg(16'h8001), 0, 2);
    v[7] = mkv(2, dg(16'h8000), dg(16'h7FFF), '0, '0, dg(16'h8000), 1, 19);
    v[8] = mkv(2, dg(16'h8001), dg(16'h0100), '0, '0, dg(16'h8001), 0, 19);
    v[9] = mkv(6, dg(16'h0200), dg(16'h0200), dg(16'h0200), dg(16'h0200), dg(16'h1000), 0, 53);

    for (int j = 0; j < 10; j++) begin
      for (int q = 0; q < NMAX; q++) jobm[q] = v[j].m[q];
      run_job(v[j].n, 1'b0, lat, tk);
      chk($sformatf("vec%0d_result", j), bus.result, v[j].er);
      chk($sformatf("vec%0d_sat", j), 256'(bus.sat), 256'(v[j].es));
      chk($sformatf("vec%0d_latency", j), 256'(lat), 256'(v[j].el));
      chk($sformatf("vec%0d_taken", j), 256'(tk), 256'(eff(v[j].n)));
    end

    // MVP: projection x view x model
    jobm[0] = '0;
    jobm[0][0] = 16'h0108; jobm[0][5] = 16'h01BB; jobm[0][10] = 16'hFCA9;
    jobm[0][11] = 16'h0990; jobm[0][14] = 16'h0100;
    jobm[1] = dg(16'h0100);
    jobm[1][3] = 16'hFDCC; jobm[1][11] = 16'hFC6A;
    jobm[2] = dg(16'h0100);
    for (int i = 0; i < 12; i++) jobm[2][i] = W'($urandom_range(0, 511) - 256);
    model(3, pexp, sexp);
    run_job(3, 1'b0, lat, tk);
    chk("mvp_result", bus.result, pexp);
    chk("mvp_sat", 256'(bus.sat), 256'(sexp));
    chk("mvp_latency", 256'(lat), 256'(36));

    // Reset in the middle of the MUL phase of an N=3 job
    @(negedge clk);
    bus.start = 1'b1; bus.num_mat = 3'd3;
    @(negedge clk);
    chk("rjob_busy_s1", 256'(bus.busy), 256'(1));
    chk("rjob_ready_s1", 256'(bus.mat_ready), 256'(1));
    bus.start = 1'b0; bus.mat_valid = 1'b1; bus.mat_in = dg(16'h7FFF);
    @(negedge clk);
    @(negedge clk);
    bus.mat_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rjob_sat_pre", 256'(bus.sat), 256'(1));
    chk("rjob_ready_mul", 256'(bus.mat_ready), 256'(0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_result", bus.result, 256'(0));
    chk("mid_rst_done", 256'(bus.done), 256'(0));
    chk("mid_rst_busy", 256'(bus.busy), 256'(0));
    chk("mid_rst_ready", 256'(bus.mat_ready), 256'(0));
    chk("mid_rst_sat", 256'(bus.sat), 256'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) jobm[0][i] = W'($urandom);
    run_job(1, 1'b0, lat, tk);
    chk("post_rst_result", bus.result, jobm[0]);
    chk("post_rst_latency", 256'(lat), 256'(2));

    // Random jobs; odd ones toggle mat_valid and pulse start while busy
    for (int j = 0; j < 10; j++) begin
      n  = $urandom_range(0, 7);
      hs = 1'(j % 2);
      for (int q = 0; q < NMAX; q++)
        for (int i = 0; i < 16; i++)
          jobm[q][i] = (j < 8) ? W'($urandom_range(0, 1023) - 512) : W'($urandom);
      model(n, pexp, sexp);
      run_job(n, hs, lat, tk);
      chk($sformatf("rnd%0d_result", j), bus.result, pexp);
      chk($sformatf("rnd%0d_sat", j), 256'(bus.sat), 256'(sexp));
      chk($sformatf("rnd%0d_taken", j), 256'(tk), 256'(eff(n)));
      if (!hs) chk($sformatf("rnd%0d_latency", j), 256'(lat), 256'(exp_lat(n)));
      @(negedge clk);
      chk($sformatf("rnd%0d_done_pulse", j), 256'(bus.done), 256'(0));
      chk($sformatf("rnd%0d_result_hold", j), bus.result, pexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
